move_scheduler: RTL
===================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter CNT_W, default 16: width of the step count per move.
REQ-002 Parameter INT_W, default 16: width of the step interval in CLK cycles.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset; synchronous and active-low, sampled on the CLK rising edge.
REQ-005 enable  input  1  1 = the scheduler may start and advance moves; 0 = freeze timing.
REQ-006 halt  input  1  1 = abort the active move and flush the buffer.
REQ-007 mv_valid  input  1  the writer offers a move.
REQ-008 mv_ready  output  1  the scheduler accepts the offered move.
REQ-009 mv_dir  input  1  direction of the offered move.
REQ-010 mv_steps  input  CNT_W  step count of the offered move.
REQ-011 mv_interval  input  INT_W  CLK cycles between steps of the offered move.
REQ-012 step  output  1  one-cycle step pulse to the phase driver.
REQ-013 dir  output  1  direction of the active or most recent move.
REQ-014 move_done  output  1  one-cycle pulse on normal completion of a move.
REQ-015 buffer_dtr  output  1  the buffer has space for at least one move.
REQ-016 busy  output  1  state is RUN or DONE.
REQ-017 steps_remaining  output  CNT_W  steps left in the active move.

Function
REQ-018 The buffer SHALL be a 2-entry FIFO of {dir, steps, interval}; a move is accepted on a cycle where mv_valid&&mv_ready.
REQ-019 mv_ready = buffer_dtr = (entries<2) && !halt && resetn, combinational.
REQ-020 States: IDLE, RUN, DONE.
REQ-021 IDLE: if enable && entries>0, pop the head, load dir, steps_remaining and interval, clear the interval counter, and go to RUN (or to DONE if steps==0) at the same edge.
REQ-022 RUN with enable=1: the counter increments each cycle; when counter==interval-1, the next edge sets step=1 for one cycle, clears the counter and decrements steps_remaining.
REQ-023 Interval 0 SHALL be treated as 1 (a step every cycle).
REQ-024 Step pulses of one move SHALL be exactly interval cycles apart; the first pulse is interval cycles after the load edge.
REQ-025 RUN with enable=0: counter, steps_remaining and step are frozen (step=0); counting resumes unchanged when enable returns to 1.
REQ-026 RUN, at the edge that makes steps_remaining 0: go to DONE.
REQ-027 DONE lasts one cycle with move_done=1.
REQ-028 Leaving DONE: if enable && entries>0, pop the next move directly into RUN/DONE without passing through IDLE; otherwise go to IDLE.
REQ-029 A simultaneous push and pop with entries==1 SHALL leave entries at 1, with FIFO order preserved.
REQ-030 With entries==2, no push occurs even if mv_valid=1.
REQ-031 halt=1 at any edge: go to IDLE; entries=0; steps_remaining=0; step=0; move_done=0 (an aborted move never signals done); dir is held.
REQ-032 The halt condition persists while halt=1.
REQ-033 dir SHALL change only on a load.
REQ-034 steps_remaining, step and move_done SHALL be registered outputs.

Reset
REQ-035 While resetn=0 at an edge: state IDLE; entries=0; counter=0; step=0; move_done=0; dir=0; steps_remaining=0; busy=0.
REQ-036 mv_ready and buffer_dtr SHALL be 0 while resetn=0, and 1 on the first cycle after release if halt=0.
REQ-037 Reset SHALL take precedence over halt and over any push.

Structure
REQ-038 A shared package rapcore_pkg SHALL hold the state enum (IDLE/RUN/DONE), the move record typedef {dir, steps, interval}, and the CNT_W/INT_W defaults.
REQ-039 One sub-module, move_fifo (2-deep, valid/ready push, pop strobe, entry count), SHALL hold the buffer; all sequencing stays in move_scheduler.

Verification
REQ-040 Push {dir=1, steps=3, interval=4} with enable=1 -> step pulses at load+4, +8 and +12; dir=1; move_done on the cycle after the third step; steps_remaining goes 3,2,1,0.
REQ-041 Push moves A{steps=2, int=2} and B{steps=1, int=3} back-to-back, then a third move -> mv_ready=0 until A is popped; B loads on the cycle after A's move_done with no IDLE gap.
REQ-042 Push {steps=0, int=5} -> no step pulse; move_done 1 cycle after the load edge.
REQ-043 During {steps=4, int=3}, drop enable for 5 cycles after the first step -> the second step is delayed by exactly 5 cycles, and the total step count stays 4.
REQ-044 Assert halt mid-move with 1 move buffered -> next edge: step=0, busy=0, entries=0, no move_done; mv_ready=0 until halt falls.
REQ-045 Apply resetn=0 during RUN -> all outputs reach the REQ-035/036 values at the next edge; a fresh move then executes normally.

Source files
------------

// File: rtl/rapcore_pkg.sv
// Shared types for the move scheduler: sequencer states, move record, default widths.
package rapcore_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int INT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                 dir;
    logic [CNT_W_DEF-1:0] steps;
    logic [INT_W_DEF-1:0] interval;
  } move_t;

endpackage

// File: rtl/move_fifo.sv
// Two-entry move buffer: push is valid/ready, pop is a strobe, head is always visible.
// Ready drops when full, during flush and while in reset; flush empties it at the next edge.
module move_fifo #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         flush_i,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e1_q;
  logic [1:0]   count_q;
  logic         push, pop, wr_hi;

  assign push_ready_o = (count_q != 2'd2) && !flush_i && resetn_i;
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_i && (count_q != 2'd0);
  // New entry lands behind the head unless a simultaneous pop makes it the head
  assign wr_hi        = (count_q == 2'd1) && !pop;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      if (flush_i)
        count_q <= 2'd0;
      else if (push && !pop)
        count_q <= count_q + 2'd1;
      else if (pop && !push)
        count_q <= count_q - 2'd1;

      if (pop)
        e0_q <= e1_q;
      if (push) begin
        if (wr_hi)
          e1_q <= push_data_i;
        else
          e0_q <= push_data_i;
      end
    end
  end

  assign head_o  = e0_q;
  assign count_o = count_q;

endmodule

// File: rtl/move_scheduler.sv
// Sequences buffered moves into step pulses spaced by the move interval; first step is
// interval cycles after the load edge. enable freezes timing, halt aborts and flushes.
module move_scheduler
  import rapcore_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int INT_W = INT_W_DEF
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             enable,
  input  logic             halt,
  input  logic             mv_valid,
  output logic             mv_ready,
  input  logic             mv_dir,
  input  logic [CNT_W-1:0] mv_steps,
  input  logic [INT_W-1:0] mv_interval,
  output logic             step,
  output logic             dir,
  output logic             move_done,
  output logic             buffer_dtr,
  output logic             busy,
  output logic [CNT_W-1:0] steps_remaining
);

  localparam int MV_W = 1 + CNT_W + INT_W;

  state_t           state_q, state_d;
  logic [INT_W-1:0] cnt_q, cnt_d, ival_q, ival_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             dir_q, dir_d, step_q, step_d, done_q, done_d;

  logic             pop, load_req;
  logic [MV_W-1:0]  head;
  logic [1:0]       entries;
  logic             head_dir;
  logic [CNT_W-1:0] head_steps;
  logic [INT_W-1:0] head_int;

  assign {head_dir, head_steps, head_int} = head;

  move_fifo #(.W(MV_W)) u_fifo (
    .clk_i        (CLK),
    .resetn_i     (resetn),
    .flush_i      (halt),
    .push_valid_i (mv_valid),
    .push_ready_o (mv_ready),
    .push_data_i  ({mv_dir, mv_steps, mv_interval}),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (entries)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ival_d   = ival_q;
    steps_d  = steps_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    pop      = 1'b0;
    load_req = 1'b0;

    case (state_q)
      IDLE: load_req = enable && (entries != 2'd0);
      RUN: begin
        if (enable) begin
          if (cnt_q == ival_q - INT_W'(1)) begin
            step_d  = 1'b1;
            cnt_d   = '0;
            steps_d = steps_q - CNT_W'(1);
            if (steps_q == CNT_W'(1))
              state_d = DONE;
          end else begin
            cnt_d = cnt_q + INT_W'(1);
          end
        end
      end
      DONE: begin
        // move_done trails the DONE cycle by one edge, i.e. the cycle after the last step
        done_d   = 1'b1;
        state_d  = IDLE;
        load_req = enable && (entries != 2'd0);
      end
      default: state_d = IDLE;
    endcase

    if (load_req) begin
      pop     = 1'b1;
      dir_d   = head_dir;
      steps_d = head_steps;
      ival_d  = (head_int == '0) ? INT_W'(1) : head_int;
      cnt_d   = '0;
      state_d = (head_steps == '0) ? DONE : RUN;
    end

    // Abort wins over everything but reset; dir is deliberately left untouched
    if (halt) begin
      state_d = IDLE;
      steps_d = '0;
      cnt_d   = '0;
      step_d  = 1'b0;
      done_d  = 1'b0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ival_q  <= '0;
      steps_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ival_q  <= ival_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign step            = step_q;
  assign dir             = dir_q;
  assign move_done       = done_q;
  assign steps_remaining = steps_q;
  assign busy            = (state_q != IDLE);
  assign buffer_dtr      = mv_ready;

endmodule
